// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel run-time half-period,
// glitch-free divisor updates at period boundaries and a registered rising-edge strobe.
module clk_div_multi #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned RESET_HALF = 6,
    parameter int unsigned SELW       = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                load,
    input  logic [SELW-1:0]     load_sel,
    input  logic [WIDTH-1:0]    load_half,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [WIDTH-1:0] HALF_INIT = WIDTH'(RESET_HALF);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0]    cnt      [CHANNELS];
    logic [WIDTH-1:0]    half     [CHANNELS];
    logic [WIDTH-1:0]    pend_val [CHANNELS];
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] stopped;
    logic [CHANNELS-1:0] toggle;
    logic [CHANNELS-1:0] apply;

    // A pending half-period is only taken when the channel is paused, stopped,
    // or at the 1->0 toggle that closes a full period, so no phase is ever cut short.
    always_comb begin
        hit     = '0;
        stopped = '0;
        toggle  = '0;
        apply   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            hit[i]     = load && (32'(load_sel) == i);
            stopped[i] = (half[i] == '0);
            toggle[i]  = enable[i] && !stopped[i] && (cnt[i] == half[i] - ONE);
            apply[i]   = pending[i] &&
                         (!enable[i] || stopped[i] || (toggle[i] && clk_out[i]));
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                cnt[i]      <= '0;
                half[i]     <= HALF_INIT;
                pend_val[i] <= '0;
                pending[i]  <= 1'b0;
                clk_out[i]  <= 1'b0;
                rise[i]     <= 1'b0;
            end else begin
                rise[i] <= 1'b0;
                if (!enable[i]) begin
                    if (apply[i]) begin
                        cnt[i] <= '0;
                    end
                end else if (stopped[i]) begin
                    cnt[i]     <= '0;
                    clk_out[i] <= 1'b0;
                end else if (toggle[i]) begin
                    cnt[i]     <= '0;
                    clk_out[i] <= ~clk_out[i];
                    rise[i]    <= ~clk_out[i];
                end else begin
                    cnt[i] <= cnt[i] + ONE;
                end

                if (apply[i]) begin
                    half[i]    <= pend_val[i];
                    pending[i] <= 1'b0;
                end

                // A load landing on the apply edge re-arms pending with the new value.
                if (hit[i]) begin
                    pend_val[i] <= load_half;
                    pending[i]  <= 1'b1;
                end
            end
        end
    end

endmodule
